// File: rtl/ber_autoalign.sv
// rtl/ber_autoalign.sv - BER checker with automatic sample-phase and reference-delay alignment
module ber_autoalign #(
    parameter int NB_DATA   = 8,
    parameter int OS        = 4,
    parameter int NB_PHASE  = 2,
    parameter int MAX_DELAY = 15,
    parameter int NB_DELAY  = 4,
    parameter int N_EVAL_PH = 64,
    parameter int N_EVAL    = 32,
    parameter int NB_ACC    = 16,
    parameter int LOCK_THR  = 0,
    parameter int LOSS_THR  = 8,
    parameter int NB_COUNT  = 64
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic signed [NB_DATA-1:0]  i_sample,
    input  logic                       i_valid,
    input  logic                       i_ref,
    output logic                       o_locked,
    output logic [1:0]                 o_state,
    output logic [NB_PHASE-1:0]        o_phase,
    output logic [NB_DELAY-1:0]        o_delay,
    output logic [NB_COUNT-1:0]        o_errors,
    output logic [NB_COUNT-1:0]        o_bits,
    output logic                       o_fail
);

    localparam int N_MAX   = (N_EVAL_PH > N_EVAL) ? N_EVAL_PH : N_EVAL;
    localparam int NB_TC   = $clog2(N_MAX);
    localparam int NB_WERR = $clog2(N_EVAL + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PHASE = 2'd1, S_DELAY = 2'd2, S_LOCK = 2'd3} state_t;

    state_t                     state_q, state_d;
    logic signed [NB_DATA-1:0]  line_q [OS];
    logic [MAX_DELAY-1:0]       hist_q;
    logic [MAX_DELAY:0]         hist_in;
    logic [NB_ACC-1:0]          acc_q [OS];
    logic [NB_ACC-1:0]          acc_d [OS];
    logic [NB_ACC-1:0]          acc_sum [OS];
    logic [NB_DATA-1:0]         abs_v [OS];
    logic [NB_PHASE-1:0]        best;
    logic [NB_TC-1:0]           cnt_q, cnt_d;
    logic [NB_WERR-1:0]         werr_q, werr_d, werr_sum;
    logic [NB_PHASE-1:0]        phase_q, phase_d;
    logic [NB_DELAY-1:0]        delay_q, delay_d;
    logic [NB_COUNT-1:0]        errors_q, errors_d, bits_q, bits_d;
    logic                       fail_q, fail_d;
    logic                       rx_bit, err_bit;

    // hist_in[k] is the reference from k strobes ago; index 0 is the live bit
    assign hist_in  = {hist_q, i_ref};
    assign rx_bit   = line_q[phase_q][NB_DATA-1];
    assign err_bit  = rx_bit ^ hist_in[delay_q];
    assign werr_sum = werr_q + NB_WERR'(err_bit);

    // Magnitude is unsigned so the most negative sample maps to 2^(NB_DATA-1)
    always_comb begin
        for (int p = 0; p < OS; p++) begin
            abs_v[p]   = line_q[p][NB_DATA-1] ? NB_DATA'(~line_q[p] + NB_DATA'(1)) : NB_DATA'(line_q[p]);
            acc_sum[p] = acc_q[p] + NB_ACC'(abs_v[p]);
        end
        best = '0;
        for (int p = 1; p < OS; p++) begin
            if (acc_sum[p] > acc_sum[best]) best = NB_PHASE'(p);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        werr_d   = werr_q;
        phase_d  = phase_q;
        delay_d  = delay_q;
        errors_d = errors_q;
        bits_d   = bits_q;
        fail_d   = 1'b0;
        if (!i_enable) begin
            state_d = S_IDLE;
            for (int p = 0; p < OS; p++) acc_d[p] = '0;
            cnt_d  = '0;
            werr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_PHASE;
                S_PHASE: if (i_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + NB_TC'(1);
                    if (cnt_q == NB_TC'(N_EVAL_PH - 1)) begin
                        phase_d = best;
                        for (int p = 0; p < OS; p++) acc_d[p] = '0;
                        cnt_d   = '0;
                        werr_d  = '0;
                        delay_d = '0;
                        state_d = S_DELAY;
                    end
                end
                S_DELAY: if (i_valid) begin
                    cnt_d  = cnt_q + NB_TC'(1);
                    werr_d = werr_sum;
                    if (cnt_q == NB_TC'(N_EVAL - 1)) begin
                        cnt_d  = '0;
                        werr_d = '0;
                        if (werr_sum <= NB_WERR'(LOCK_THR)) begin
                            state_d  = S_LOCK;
                            errors_d = '0;
                            bits_d   = '0;
                        end else if (delay_q < NB_DELAY'(MAX_DELAY)) begin
                            delay_d = delay_q + NB_DELAY'(1);
                        end else begin
                            fail_d  = 1'b1;
                            delay_d = '0;
                            state_d = S_PHASE;
                        end
                    end
                end
                S_LOCK: if (i_valid) begin
                    if (bits_q != '1) bits_d = bits_q + NB_COUNT'(1);
                    if (err_bit && errors_q != '1) errors_d = errors_q + NB_COUNT'(1);
                    cnt_d  = cnt_q + NB_TC'(1);
                    werr_d = werr_sum;
                    if (cnt_q == NB_TC'(N_EVAL - 1)) begin
                        cnt_d  = '0;
                        werr_d = '0;
                        if (werr_sum > NB_WERR'(LOSS_THR)) state_d = S_PHASE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            for (int p = 0; p < OS; p++) begin
                line_q[p] <= '0;
                acc_q[p]  <= '0;
            end
            hist_q   <= '0;
            cnt_q    <= '0;
            werr_q   <= '0;
            phase_q  <= '0;
            delay_q  <= '0;
            errors_q <= '0;
            bits_q   <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q[0] <= i_sample;
            for (int p = 1; p < OS; p++) line_q[p] <= line_q[p-1];
            if (i_valid) hist_q <= hist_in[MAX_DELAY-1:0];
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            werr_q   <= werr_d;
            phase_q  <= phase_d;
            delay_q  <= delay_d;
            errors_q <= errors_d;
            bits_q   <= bits_d;
            fail_q   <= fail_d;
        end
    end

    assign o_locked = (state_q == S_LOCK);
    assign o_state  = state_q;
    assign o_phase  = phase_q;
    assign o_delay  = delay_q;
    assign o_errors = errors_q;
    assign o_bits   = bits_q;
    assign o_fail   = fail_q;

endmodule

// File: tb/tb_ber_autoalign.sv
// tb/tb_ber_autoalign.sv - directed checks of ber_autoalign acquisition, lock, loss, failure and saturation
module tb_ber_autoalign;

    logic              clock = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_enable = 1'b1;
    logic signed [7:0] i_sample = '0;
    logic signed [7:0] i_sample_b = '0;
    logic              i_valid = 1'b0;
    logic              i_ref = 1'b0;
    logic              o_locked, o_fail;
    logic [1:0]        o_state;
    logic [1:0]        o_phase;
    logic [3:0]        o_delay;
    logic [63:0]       o_errors, o_bits;
    logic              s_locked, s_fail;
    logic [1:0]        s_state, s_phase;
    logic [3:0]        s_delay;
    logic [5:0]        s_errors, s_bits;

    ber_autoalign dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(i_sample),
        .i_valid(i_valid), .i_ref(i_ref), .o_locked(o_locked), .o_state(o_state),
        .o_phase(o_phase), .o_delay(o_delay), .o_errors(o_errors), .o_bits(o_bits), .o_fail(o_fail)
    );

    // Narrow counters and an unreachable loss threshold let saturation be reached while locked
    ber_autoalign #(.NB_COUNT(6), .LOSS_THR(32)) dut_sat (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(i_sample_b),
        .i_valid(i_valid), .i_ref(i_ref), .o_locked(s_locked), .o_state(s_state),
        .o_phase(s_phase), .o_delay(s_delay), .o_errors(s_errors), .o_bits(s_bits), .o_fail(s_fail)
    );

    always #5 clock = ~clock;

    typedef struct {
        int scen; int cyc; int st; int ph; int dl; int lk; int fl; int fc; int err; int bits;
    } vec_t;

    vec_t tbl[$];
    bit   prbs [2048];
    int   pat [4] = '{20, 40, 100, 40};
    int   c, fail_cnt, n_pass, n_total;
    bit   inv_on, ref_zero, inv_b;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c - 1, act, exp);
    endtask

    // Symbol k spans cycles 4k..4k+3; the strobe at 4k+3 sees the peak sample of 4k on line[2]
    task automatic drive();
        int  k, mag;
        bit  rx;
        k   = c / 4;
        mag = pat[(c % 4 + 2) % 4];
        rx  = prbs[k] ^ (inv_on && k >= 264 && k <= 279);
        i_sample   = rx ? 8'(-mag) : 8'(mag);
        i_sample_b = (rx ^ inv_b) ? 8'(-mag) : 8'(mag);
        i_valid    = (c % 4 == 3);
        i_ref      = ref_zero ? 1'b0 : prbs[k + 5];
    endtask

    task automatic step();
        drive();
        @(posedge clock);
        #1;
        if (o_fail) fail_cnt++;
        c++;
    endtask

    task automatic run_to(input int n);
        while (c <= n) step();
    endtask

    task automatic reset_dut();
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_sample   = 8'($urandom);
            i_sample_b = 8'($urandom);
            @(posedge clock);
            #1;
        end
        chk("rst_state", o_state, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_errors", o_errors, 0);
        chk("rst_bits", o_bits, 0);
        chk("rst_phase", o_phase, 0);
        chk("rst_delay", o_delay, 0);
        chk("rst_fail", o_fail, 0);
        i_reset  = 1'b0;
        c        = 0;
        fail_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] lfsr;
        int         cur;
        lfsr = 9'h1FF;
        for (int i = 0; i < 2048; i++) begin
            prbs[i] = lfsr[0];
            lfsr    = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
        n_pass = 0; n_total = 0;

        // scenario 0: clean lock at delay 5, 16 inverted symbols in the first window, re-lock
        tbl.push_back('{0,    0, 1, 0, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{0,  254, 1, 0, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{0,  255, 2, 2, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{0,  382, 2, 2, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{0,  383, 2, 2, 1, 0, 0, 0,  0,  0});
        tbl.push_back('{0, 1022, 2, 2, 5, 0, 0, 0,  0,  0});
        tbl.push_back('{0, 1023, 3, 2, 5, 1, 0, 0,  0,  0});
        tbl.push_back('{0, 1027, 3, 2, 5, 1, 0, 0,  0,  1});
        tbl.push_back('{0, 1055, 3, 2, 5, 1, 0, 0,  0,  8});
        tbl.push_back('{0, 1087, 3, 2, 5, 1, 0, 0,  8, 16});
        tbl.push_back('{0, 1150, 3, 2, 5, 1, 0, 0, 16, 31});
        tbl.push_back('{0, 1151, 1, 2, 5, 0, 0, 0, 16, 32});
        tbl.push_back('{0, 1407, 2, 2, 0, 0, 0, 0, 16, 32});
        tbl.push_back('{0, 2174, 2, 2, 5, 0, 0, 0, 16, 32});
        tbl.push_back('{0, 2175, 3, 2, 5, 1, 0, 0,  0,  0});
        tbl.push_back('{0, 2179, 3, 2, 5, 1, 0, 0,  0,  1});
        // scenario 1: reference stuck at 0, every sweep fails
        tbl.push_back('{1,    0, 1, 0, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{1,  255, 2, 2, 0, 0, 0, 0,  0,  0});
        tbl.push_back('{1, 2302, 2, 2, 15, 0, 0, 0, 0,  0});
        tbl.push_back('{1, 2303, 1, 2, 0, 0, 1, 1,  0,  0});
        tbl.push_back('{1, 2304, 1, 2, 0, 0, 0, 1,  0,  0});
        tbl.push_back('{1, 2559, 2, 2, 0, 0, 0, 1,  0,  0});
        tbl.push_back('{1, 4606, 2, 2, 15, 0, 0, 1, 0,  0});
        tbl.push_back('{1, 4607, 1, 2, 0, 0, 1, 2,  0,  0});
        tbl.push_back('{1, 4610, 1, 2, 0, 0, 0, 2,  0,  0});

        cur = -1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].scen != cur) begin
                cur      = tbl[i].scen;
                inv_on   = (cur == 0);
                ref_zero = (cur == 1);
                inv_b    = 1'b0;
                reset_dut();
            end
            run_to(tbl[i].cyc);
            chk("state", o_state, tbl[i].st);
            chk("phase", o_phase, tbl[i].ph);
            chk("delay", o_delay, tbl[i].dl);
            chk("locked", o_locked, tbl[i].lk);
            chk("fail", o_fail, tbl[i].fl);
            chk("fail_pulses", fail_cnt, tbl[i].fc);
            chk("errors", o_errors, tbl[i].err);
            chk("bits", o_bits, tbl[i].bits);
        end

        // enable dropped mid-trial and restored
        inv_on = 0; ref_zero = 0; inv_b = 0;
        reset_dut();
        run_to(499);
        chk("en_pre_state", o_state, 2);
        chk("en_pre_delay", o_delay, 1);
        i_enable = 1'b0;
        run_to(500);
        chk("en_off_state", o_state, 0);
        chk("en_off_phase", o_phase, 2);
        chk("en_off_delay", o_delay, 1);
        chk("en_off_bits", o_bits, 0);
        run_to(503);
        chk("en_off_hold", o_state, 0);
        i_enable = 1'b1;
        run_to(504);
        chk("en_on_state", o_state, 1);
        chk("en_on_delay", o_delay, 1);
        run_to(758);
        chk("en_phase_run", o_state, 1);
        run_to(759);
        chk("en_phase_done", o_state, 2);
        chk("en_phase_delay", o_delay, 0);
        run_to(1526);
        chk("en_relock_pre", o_state, 2);
        run_to(1527);
        chk("en_relock", o_state, 3);
        chk("en_relock_delay", o_delay, 5);

        // saturation with continuous errors on the narrow-counter instance
        reset_dut();
        run_to(1023);
        chk("sat_locked", s_locked, 1);
        chk("sat_delay", s_delay, 5);
        inv_b = 1'b1;
        run_to(1271);
        chk("sat_err_62", s_errors, 62);
        run_to(1275);
        chk("sat_err_63", s_errors, 63);
        chk("sat_bits_63", s_bits, 63);
        run_to(1279);
        chk("sat_err_hold", s_errors, 63);
        chk("sat_bits_hold", s_bits, 63);
        run_to(1400);
        chk("sat_err_end", s_errors, 63);
        chk("sat_state_end", s_state, 3);
        chk("main_err_clean", o_errors, 0);
        chk("main_bits_run", o_bits, 94);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
